split_driver: RTL and testbench

SPLIT_DRIVER -- requirements
Module: split_driver

---
 rtl/split_pkg.sv | 16 +
 rtl/split_word_loader.sv | 69 ++++++
 rtl/split_driver.sv | 108 ++++++++++
 tb/tb_split_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/split_pkg.sv
// Shared types and sizing helpers for the split constraint checker driver.
package split_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } split_state_e;

    localparam int WORD_W_DEFAULT = 32;

    function automatic int calc_nwords(input int total_bits, input int word_w);
        return (total_bits + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/split_word_loader.sv
// Assembles load words into the packed assignment vector and flags word-count errors.
module split_word_loader
    import split_pkg::*;
#(
    parameter int TOTAL_BITS = 1300,
    parameter int WORD_W     = WORD_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  xfer_i,
    input  logic                  clear_i,
    input  logic [WORD_W-1:0]     data_i,
    input  logic                  last_i,
    output logic [TOTAL_BITS-1:0] vec_o,
    output logic                  err_o
);

    localparam int NWORDS = calc_nwords(TOTAL_BITS, WORD_W);
    localparam int IDX_W  = $clog2(NWORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    // The index parks at NWORDS while surplus words are drained.
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NWORDS);

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic [TOTAL_BITS-1:0] vec_q, vec_d;

    for (genvar k = 0; k < NWORDS; k++) begin : g_slot
        localparam int LO  = k * WORD_W;
        localparam int W_K = (TOTAL_BITS - LO < WORD_W) ? (TOTAL_BITS - LO) : WORD_W;
        logic hit;
        assign hit = xfer_i && (idx_q == IDX_W'(k));
        assign vec_d[LO +: W_K] = hit ? data_i[W_K-1:0] : vec_q[LO +: W_K];
    end

    always_comb begin
        idx_d = idx_q;
        err_d = err_q;
        if (clear_i) begin
            idx_d = '0;
            err_d = 1'b0;
        end else if (xfer_i) begin
            if (idx_q != FULL_IDX) begin
                idx_d = idx_q + 1'b1;
            end
            if (last_i) begin
                err_d = err_q | (idx_q != LAST_IDX);
            end else begin
                err_d = err_q | (idx_q == FULL_IDX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            err_q <= 1'b0;
            vec_q <= '0;
        end else begin
            idx_q <= idx_d;
            err_q <= err_d;
            vec_q <= vec_d;
        end
    end

    assign vec_o = vec_q;
    assign err_o = err_q;

endmodule

// File: rtl/split_driver.sv
// Loads one assignment into a split checker, waits its latency, and returns the verdict.
module split_driver
    import split_pkg::*;
#(
    parameter int TOTAL_BITS = 1300,
    parameter int WORD_W     = WORD_W_DEFAULT,
    parameter int CHK_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_last,
    output logic [TOTAL_BITS-1:0] assign_vec,
    input  logic                  chk_x,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_sat,
    output logic                  res_err,
    output logic [15:0]           sat_count,
    output split_state_e          dbg_state
);

    // Handshakes: a word moves when in_valid && in_ready, a result when res_valid && res_ready;
    // in_ready and res_valid depend only on registered state.
    localparam logic [3:0] LAT_LAST = 4'(CHK_LAT - 1);

    split_state_e state_q, state_d;
    logic [3:0]   wait_q, wait_d;
    logic         sat_q, sat_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         xfer;
    logic         handoff;
    logic         err;

    assign in_ready  = (state_q == LOAD);
    assign res_valid = (state_q == RESP);
    assign xfer      = in_valid && in_ready;
    assign handoff   = res_valid && res_ready;

    split_word_loader #(
        .TOTAL_BITS(TOTAL_BITS),
        .WORD_W    (WORD_W)
    ) u_loader (
        .clk    (clk),
        .rst    (rst),
        .xfer_i (xfer),
        .clear_i(handoff),
        .data_i (in_data),
        .last_i (in_last),
        .vec_o  (assign_vec),
        .err_o  (err)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LOAD: begin
                if (xfer && in_last) begin
                    state_d = EVAL;
                    wait_d  = '0;
                end
            end
            EVAL: begin
                if (wait_q == LAT_LAST) begin
                    state_d = RESP;
                    wait_d  = '0;
                    sat_d   = chk_x;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = LOAD;
                    if (sat_q && !err && cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            wait_q  <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_sat   = sat_q;
    assign res_err   = err;
    assign sat_count = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_split_driver.sv
// Directed bench for split_driver: vector table of assignments plus hand-written corner sequences.
module tb_split_driver;
    import split_pkg::*;

    localparam int TOTAL_BITS = 1300;
    localparam int WORD_W     = 32;
    localparam int NWORDS     = 41;
    localparam int CHK_LAT    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_W-1:0]     in_data;
    logic                  in_last;
    logic [TOTAL_BITS-1:0] assign_vec;
    logic                  chk_x;
    logic                  res_valid;
    logic                  res_ready;
    logic                  res_sat;
    logic                  res_err;
    logic [15:0]           sat_count;
    split_state_e          dbg_state;

    split_driver #(
        .TOTAL_BITS(TOTAL_BITS),
        .WORD_W    (WORD_W),
        .CHK_LAT   (CHK_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .assign_vec(assign_vec),
        .chk_x     (chk_x),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sat   (res_sat),
        .res_err   (res_err),
        .sat_count (sat_count),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [TOTAL_BITS-1:0] exp_vec;

    typedef struct {
        int          n_words;
        logic        chk;
        logic        exp_sat;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name);
        n_checks++;
        if (assign_vec !== exp_vec) begin
            int first_bad = -1;
            n_errors++;
            for (int b = TOTAL_BITS - 1; b >= 0; b--) begin
                if (assign_vec[b] !== exp_vec[b]) first_bad = b;
            end
            $display("FAIL %s assign_vec bit %0d actual=%b required=%b", name, first_bad,
                     assign_vec[first_bad], exp_vec[first_bad]);
        end
    endtask

    // Word k covers bits k*32..k*32+31; anything at or above TOTAL_BITS is thrown away.
    task automatic model_word(input int k, input logic [WORD_W-1:0] w);
        for (int b = 0; b < WORD_W; b++) begin
            if (k < NWORDS && k * WORD_W + b < TOTAL_BITS) exp_vec[k * WORD_W + b] = w[b];
        end
    endtask

    task automatic send_words(input int n, input bit with_last, input logic chk);
        for (int k = 0; k < n; k++) begin
            logic [WORD_W-1:0] w;
            int g;
            w = $urandom();
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w;
            in_last  = with_last && (k == n - 1);
            chk_x    = chk;
            g = 0;
            while (!in_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (g >= 20) check("in_ready_wait", 32'(in_ready), 32'd1);
            model_word(k, w);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input int start, output int lat);
        lat = start;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handoff(input logic [15:0] exp_cnt, input string name);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({name, "_res_valid_after"}, 32'(res_valid), 32'd0);
        check({name, "_sat_count"}, 32'(sat_count), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;

        tbl[0] = '{n_words: 41, chk: 1'b1, exp_sat: 1'b1, exp_err: 1'b0, exp_cnt: 16'd1};
        tbl[1] = '{n_words: 11, chk: 1'b1, exp_sat: 1'b1, exp_err: 1'b1, exp_cnt: 16'd1};
        tbl[2] = '{n_words: 43, chk: 1'b1, exp_sat: 1'b1, exp_err: 1'b1, exp_cnt: 16'd1};
        tbl[3] = '{n_words: 41, chk: 1'b0, exp_sat: 1'b0, exp_err: 1'b0, exp_cnt: 16'd1};
        tbl[4] = '{n_words: 1,  chk: 1'b1, exp_sat: 1'b1, exp_err: 1'b1, exp_cnt: 16'd1};
        tbl[5] = '{n_words: 41, chk: 1'b1, exp_sat: 1'b1, exp_err: 1'b0, exp_cnt: 16'd2};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        chk_x = 1'b0; res_ready = 1'b0;
        exp_vec = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_sat", 32'(res_sat), 32'd0);
        check("reset_res_err", 32'(res_err), 32'd0);
        check("reset_sat_count", 32'(sat_count), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(LOAD));
        check_vec("reset_vec");

        for (int i = 0; i < 6; i++) begin
            send_words(tbl[i].n_words, 1'b1, tbl[i].chk);
            wait_result(1, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(CHK_LAT + 1));
            check($sformatf("v%0d_res_sat", i), 32'(res_sat), 32'(tbl[i].exp_sat));
            check($sformatf("v%0d_res_err", i), 32'(res_err), 32'(tbl[i].exp_err));
            check($sformatf("v%0d_in_ready_resp", i), 32'(in_ready), 32'd0);
            check_vec($sformatf("v%0d_vec", i));
            handoff(tbl[i].exp_cnt, $sformatf("v%0d", i));
        end

        // chk_x is only sampled on the final EVAL cycle, then held through a stalled RESP.
        send_words(NWORDS, 1'b1, 1'b0);
        @(negedge clk);
        chk_x = 1'b1;
        wait_result(2, lat);
        check("bp_latency", 32'(lat), 32'(CHK_LAT + 1));
        chk_x = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = $urandom();
            in_last  = 1'b1;
            @(negedge clk);
            check($sformatf("bp%0d_res_valid", c), 32'(res_valid), 32'd1);
            check($sformatf("bp%0d_res_sat", c), 32'(res_sat), 32'd1);
            check($sformatf("bp%0d_res_err", c), 32'(res_err), 32'd0);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            check_vec($sformatf("bp%0d_vec", c));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handoff(16'd3, "bp");

        // Reset in the middle of a load discards it and clears everything.
        send_words(21, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_vec = '0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_sat_count", 32'(sat_count), 32'd0);
        check_vec("midrst_vec");
        send_words(NWORDS, 1'b1, 1'b1);
        wait_result(1, lat);
        check("midrst_latency", 32'(lat), 32'(CHK_LAT + 1));
        check("midrst_res_sat", 32'(res_sat), 32'd1);
        check("midrst_res_err", 32'(res_err), 32'd0);
        check_vec("midrst_full_vec");
        handoff(16'd1, "midrst");

        // Saturation: preset near the top instead of running 65534 assignments.
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        check("sat_preset", 32'(sat_count), 32'hFFFE);
        for (int p = 0; p < 2; p++) begin
            send_words(NWORDS, 1'b1, 1'b1);
            wait_result(1, lat);
            check($sformatf("sat%0d_res_sat", p), 32'(res_sat), 32'd1);
            handoff(16'hFFFF, $sformatf("sat%0d", p));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
